lab2_serial_subtractor: RTL
===========================

# lab2_serial_subtractor

Bit-serial 4-bit subtractor, the reverse-direction companion of the board's combinational 4-bit ripple adder. It computes A − B − BIN one bit per clock through a single full-subtractor cell and a borrow flip-flop, started by a debounced pushbutton. It uses the same switch/LED mapping as the adder, so the two labs share one pin assignment file.

## Interface
- SYNC_STAGES, 2, number of synchroniser flops on KEY[1] (≥2)
- CLOCK_50  input  1  system clock, all state on rising edge
- KEY  input  2  KEY[0]: asynchronous active-low reset; KEY[1]: active-low start pushbutton (asynchronous to clock)
- SW  input  9  SW[7:4] = A, SW[3:0] = B, SW[8] = BIN (borrow-in)
- LEDR  output  10  LEDR[3:0] = difference, LEDR[4] = borrow-out, LEDR[7:5] = 0, LEDR[8] = done, LEDR[9] = busy

## Operation
- Reset: KEY[0] low clears every flop immediately, without waiting for a clock edge. State = IDLE; LEDR = 10'b0; shift registers, bit counter, borrow flop and synchroniser all 0. The synchroniser resets to the "released" level, so a button held through reset is not seen as a press.
- Start detect: KEY[1] passes through SYNC_STAGES flops and is inverted. A one-cycle `start` pulse fires on the synchronised falling edge (press). Holding the button produces exactly one pulse.
- FSM states: IDLE, SHIFT, DONE.
  - IDLE/DONE + start: latch A, B and BIN into operand registers, clear the bit counter, go to SHIFT. Set busy = 1 and done = 0. LEDR[4:0] keeps its previous value.
  - SHIFT: each cycle processes bit i (LSB first) from a = A[i], b = B[i], bw = borrow flop.
    - d = a ^ b ^ bw
    - bw' = (~a & b) | (~(a ^ b) & bw)
    - d shifts into the result register from the MSB side; the operands shift right; the counter increments.
  - SHIFT with counter == 3: after bit 3, go to DONE. Load LEDR[3:0] with the 4-bit difference and LEDR[4] with the final borrow. Set done = 1 and busy = 0.
  - DONE: results are held until the next start. No other exit except reset.
- Arithmetic: LEDR[4:0] = {borrow, diff} such that A − B − BIN = diff − 16·borrow. A and B are unsigned 0..15. The result wraps modulo 16, and borrow = 1 exactly when A < B + BIN.
- Start pulses while busy = 1 are ignored; they are not queued.
- SW changes after the capture edge have no effect on the running operation.
- LEDR[7:5] is tied to 0.

## Timing
- Button-to-start latency: SYNC_STAGES + 1 cycles from the first CLOCK_50 edge that samples KEY[1] low.
- Let the capture edge be E0, where the `start` pulse is sampled. Bits 0..3 are processed on edges E1..E4.
- At E4: LEDR[4:0] is updated, done rises and busy falls. A result is visible exactly 4 cycles after capture.
- busy is high for exactly 4 cycles per operation. done stays high from E4 until the next capture edge.
- A start in the DONE state is accepted on the same rules as in IDLE. Back-to-back operations therefore need at minimum 5 cycles plus button latency.
- Reset assertion mid-SHIFT aborts the operation: LEDR = 0 immediately and state = IDLE. Reset release is synchronised by the system; the block needs no extra deassertion delay.
- All outputs are registered; there is no combinational path from SW or KEY to LEDR.

## Test plan
- Reset: hold KEY[0]=0 with random SW and KEY[1] toggling → LEDR = 10'h000 throughout. Release with KEY[1] held low → no operation starts.
- A=7, B=3, BIN=0, press once → busy for 4 cycles, then LEDR[4:0] = 5'b0_0100, done=1, busy=0.
- A=3, B=7, BIN=0 → LEDR[4:0] = 5'b1_1100. Then A=0, B=0, BIN=1 → 5'b1_1111. Then A=15, B=15, BIN=0 → 5'b0_0000.
- Exhaustive: all 512 SW values with a press each → every result equals {A<B+BIN, (A−B−BIN) mod 16}, with latency exactly 4 cycles after capture.
- During SHIFT, change SW and pulse KEY[1] again → the result reflects the originally captured operands, and only one operation occurs (busy high for exactly 4 cycles).
- Assert KEY[0] two cycles into SHIFT → LEDR = 0 asynchronously. After release, a fresh press with A=9, B=4 → 5'b0_0101.

Source files
------------

// File: rtl/lab2_serial_subtractor.sv
// Bit-serial 4-bit subtractor: computes A - B - BIN one bit per clock (LSB first)
// through a single full-subtractor cell and a borrow flop, started by a pushbutton.
//
// Ports:
//   CLOCK_50  system clock, all state on the rising edge
//   KEY[0]    asynchronous active-low reset
//   KEY[1]    active-low start pushbutton, asynchronous to the clock
//   SW[7:4]   operand A, SW[3:0] operand B, SW[8] borrow-in
//   LEDR[3:0] difference, LEDR[4] borrow-out, LEDR[7:5] zero,
//   LEDR[8]   done, LEDR[9] busy (all registered)
module lab2_serial_subtractor #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic       CLOCK_50,
  input  logic [1:0] KEY,
  input  logic [8:0] SW,
  output logic [9:0] LEDR
);

  logic clk;
  logic rst_n;
  assign clk   = CLOCK_50;
  assign rst_n = KEY[0];

  typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

  // Start detect. The chain holds the inverted (pressed = 1) level and resets to
  // "released". A parallel valid chain marks when the chain output reflects a real
  // sample; the detector only arms after a genuine released level, so a button held
  // through reset is never seen as a press.
  logic [SYNC_STAGES-1:0] sync_q;
  logic [SYNC_STAGES-1:0] vld_q;
  logic                   prev_q;
  logic                   armed_q;
  logic                   pressed;
  logic                   start;

  assign pressed = sync_q[SYNC_STAGES-1];
  assign start   = armed_q & pressed & ~prev_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q  <= '0;
      vld_q   <= '0;
      prev_q  <= 1'b0;
      armed_q <= 1'b0;
    end else begin
      sync_q  <= {sync_q[SYNC_STAGES-2:0], ~KEY[1]};
      vld_q   <= {vld_q[SYNC_STAGES-2:0], 1'b1};
      prev_q  <= pressed;
      armed_q <= armed_q | (vld_q[SYNC_STAGES-1] & ~pressed);
    end
  end

  // Datapath and control state
  state_e     state_q, state_d;
  logic [3:0] a_q, a_d;
  logic [3:0] b_q, b_d;
  logic [3:0] res_q, res_d;
  logic       bw_q, bw_d;
  logic [1:0] cnt_q, cnt_d;
  logic [3:0] diff_q, diff_d;
  logic       bout_q, bout_d;
  logic       done_q, done_d;
  logic       busy_q, busy_d;

  // Full-subtractor cell on the current LSBs
  logic a_bit, b_bit, d_bit, bw_next;
  assign a_bit   = a_q[0];
  assign b_bit   = b_q[0];
  assign d_bit   = a_bit ^ b_bit ^ bw_q;
  assign bw_next = (~a_bit & b_bit) | (~(a_bit ^ b_bit) & bw_q);

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    bw_d    = bw_q;
    cnt_d   = cnt_q;
    diff_d  = diff_q;
    bout_d  = bout_q;
    done_d  = done_q;
    busy_d  = busy_q;

    unique case (state_q)
      StIdle, StDone: begin
        if (start) begin
          a_d     = SW[7:4];
          b_d     = SW[3:0];
          bw_d    = SW[8];
          res_d   = '0;
          cnt_d   = '0;
          busy_d  = 1'b1;
          done_d  = 1'b0;
          state_d = StShift;
        end
      end
      StShift: begin
        // Difference bits enter from the MSB side so bit 0 ends up at res[0].
        res_d = {d_bit, res_q[3:1]};
        a_d   = {1'b0, a_q[3:1]};
        b_d   = {1'b0, b_q[3:1]};
        bw_d  = bw_next;
        cnt_d = cnt_q + 2'd1;
        if (cnt_q == 2'd3) begin
          diff_d  = {d_bit, res_q[3:1]};
          bout_d  = bw_next;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = StDone;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      bw_q    <= 1'b0;
      cnt_q   <= '0;
      diff_q  <= '0;
      bout_q  <= 1'b0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      bw_q    <= bw_d;
      cnt_q   <= cnt_d;
      diff_q  <= diff_d;
      bout_q  <= bout_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
    end
  end

  assign LEDR = {busy_q, done_q, 3'b000, bout_q, diff_q};

endmodule
